// File: rtl/sfq_pkg.sv
// Shared types and sizing helpers for the N-way toggle-encoded SFQ splitter.
package sfq_pkg;

  typedef enum logic {INIT, RUN} sfq_state_t;

  localparam int unsigned N_OUT_MIN = 2;
  localparam int unsigned N_OUT_MAX = 32;
  localparam int unsigned DELAY_MIN = 1;
  localparam int unsigned DELAY_MAX = 16;

  // Bits needed for a down/up counter spanning 0..max_val-1 (never less than 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/sfq_pulse_delay_line.sv
// Fixed-latency single-bit event pipe: an event in at edge k appears on ev_out
// so that it is consumed at edge k+DELAY.
module sfq_pulse_delay_line #(
  parameter int unsigned DELAY = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ev_in,
  output logic ev_out
);

  logic [DELAY-1:0] sr;

  generate
    if (DELAY == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= '0;
        else        sr <= ev_in;
      end
    end else begin : g_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= '0;
        else        sr <= {sr[DELAY-2:0], ev_in};
      end
    end
  endgenerate

  assign ev_out = sr[DELAY-1];

endmodule

// File: rtl/sfq_splitt_n.sv
// N-way toggle-encoded SFQ splitter: start-up hold-off, inter-pulse constraint
// check with sticky/counted violations, fixed delay and per-branch enable mask.
module sfq_splitt_n
  import sfq_pkg::*;
#(
  parameter int unsigned N_OUT        = 4,
  parameter int unsigned DELAY        = 3,
  parameter int unsigned CT           = 4,
  parameter int unsigned BEGIN_CYCLES = 8,
  parameter bit          VIOL_DROP    = 1'b0,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic [N_OUT-1:0] en_mask,
  output logic [N_OUT-1:0] q,
  output logic             ready,
  output logic             viol,
  output logic [CNT_W-1:0] viol_count
);

  localparam int unsigned BW = cnt_width(BEGIN_CYCLES);
  localparam int unsigned CW = cnt_width(CT);
  localparam logic [BW-1:0] INIT_LAST = (BEGIN_CYCLES > 1) ? BW'(BEGIN_CYCLES - 1) : '0;
  localparam logic [CW-1:0] CD_LOAD   = (CT > 1) ? CW'(CT - 1) : '0;

  sfq_state_t    state;
  logic [BW-1:0] init_cnt;
  logic [CW-1:0] cooldown;
  logic          a_prev;
  logic          prime;
  logic          ev_raw;
  logic          violation;
  logic          accept;
  logic          ev_out;

  // cooldown != 0 can only happen with CT >= 2, so CT=0/1 never flags.
  always_comb begin
    ev_raw    = !prime && (a != a_prev);
    violation = ev_raw && (state == RUN) && (cooldown != '0);
    accept    = ev_raw && (state == RUN) && !(violation && VIOL_DROP);
  end

  sfq_pulse_delay_line #(
    .DELAY(DELAY)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .ev_in (accept),
    .ev_out(ev_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      init_cnt   <= '0;
      ready      <= 1'b0;
      a_prev     <= 1'b0;
      prime      <= 1'b1;
      cooldown   <= '0;
      viol       <= 1'b0;
      viol_count <= '0;
      q          <= '0;
    end else begin
      a_prev <= a;
      prime  <= 1'b0;

      unique case (state)
        INIT: begin
          if (BEGIN_CYCLES == 0 || init_cnt == INIT_LAST) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        RUN: ;
        default: state <= INIT;
      endcase

      if (accept)                cooldown <= CD_LOAD;
      else if (cooldown != '0)   cooldown <= cooldown - 1'b1;

      if (violation) begin
        viol <= 1'b1;
        if (viol_count != '1) viol_count <= viol_count + 1'b1;
      end

      if (ev_out) q <= q ^ en_mask;
    end
  end

endmodule

// File: tb/tb_sfq_splitt_n.sv
// Directed bench for sfq_splitt_n: propagate and drop variants driven in lockstep.
module tb_sfq_splitt_n;

  logic       clk;
  logic       rst_n;
  logic       a;
  logic [3:0] en_mask;

  logic [3:0] q_p, q_d;
  logic       ready_p, ready_d;
  logic       viol_p, viol_d;
  logic [7:0] vc_p, vc_d;

  int unsigned n_vec;
  int unsigned n_err;
  int unsigned edge_n;

  sfq_splitt_n #(
    .N_OUT(4), .DELAY(3), .CT(4), .BEGIN_CYCLES(8), .VIOL_DROP(1'b0), .CNT_W(8)
  ) u_dut_prop (
    .clk(clk), .rst_n(rst_n), .a(a), .en_mask(en_mask),
    .q(q_p), .ready(ready_p), .viol(viol_p), .viol_count(vc_p)
  );

  sfq_splitt_n #(
    .N_OUT(4), .DELAY(3), .CT(4), .BEGIN_CYCLES(8), .VIOL_DROP(1'b1), .CNT_W(8)
  ) u_dut_drop (
    .clk(clk), .rst_n(rst_n), .a(a), .en_mask(en_mask),
    .q(q_d), .ready(ready_d), .viol(viol_d), .viol_count(vc_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic go_to(input int unsigned n);
    while (edge_n < n) tick();
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    edge_n  = 0;
    rst_n   = 1'b0;
    a       = 1'b1;
    en_mask = 4'hF;

    repeat (2) @(posedge clk);
    #1;
    check("rst_q_p",     32'(q_p),     32'h0);
    check("rst_q_d",     32'(q_d),     32'h0);
    check("rst_ready",   32'(ready_p), 32'h0);
    check("rst_viol",    32'(viol_p),  32'h0);
    check("rst_vc",      32'(vc_p),    32'h0);
    rst_n = 1'b1;

    // a held high through reset must not count as a pulse
    go_to(7);
    check("init_ready7", 32'(ready_p), 32'h0);
    check("init_q7",     32'(q_p),     32'h0);
    go_to(8);
    check("init_ready8_p", 32'(ready_p), 32'h1);
    check("init_ready8_d", 32'(ready_d), 32'h1);
    check("init_viol8",    32'(viol_p),  32'h0);
    go_to(12);
    check("init_q12",      32'(q_p),     32'h0);

    // single pulse sampled at edge 20 -> all outputs toggle at 23
    go_to(19); a = ~a;
    go_to(22);
    check("p20_q22", 32'(q_p), 32'h0);
    go_to(23);
    check("p20_q23_p", 32'(q_p), 32'hF);
    check("p20_q23_d", 32'(q_d), 32'hF);
    go_to(29);
    check("p20_hold", 32'(q_p), 32'hF);
    check("p20_noviol", 32'(viol_p), 32'h0);

    // pulses at 30, 32, 34 with CT=4
    a = ~a;
    go_to(31); a = ~a;
    go_to(32);
    check("v32_viol_p", 32'(viol_p), 32'h1);
    check("v32_vc_p",   32'(vc_p),   32'h1);
    check("v32_viol_d", 32'(viol_d), 32'h1);
    check("v32_vc_d",   32'(vc_d),   32'h1);
    check("v32_q_p",    32'(q_p),    32'hF);
    go_to(33); a = ~a;
    check("v33_q_p", 32'(q_p), 32'h0);
    check("v33_q_d", 32'(q_d), 32'h0);
    go_to(34);
    check("v34_vc_p", 32'(vc_p), 32'h2);
    check("v34_vc_d", 32'(vc_d), 32'h1);
    go_to(35);
    check("v35_q_p", 32'(q_p), 32'hF);
    check("v35_q_d", 32'(q_d), 32'h0);
    go_to(36);
    check("v36_q_d", 32'(q_d), 32'h0);
    go_to(37);
    check("v37_q_p", 32'(q_p), 32'h0);
    check("v37_q_d", 32'(q_d), 32'hF);

    // masked emergence at 43, full mask at 49
    go_to(39); a = ~a;
    go_to(42);
    check("m42_q_p", 32'(q_p), 32'h0);
    en_mask = 4'b0101;
    go_to(43);
    check("m43_q_p", 32'(q_p), 32'h5);
    check("m43_q_d", 32'(q_d), 32'hA);
    en_mask = 4'hF;
    go_to(45); a = ~a;
    go_to(48);
    check("m48_q_p", 32'(q_p), 32'h5);
    go_to(49);
    check("m49_q_p", 32'(q_p), 32'hA);
    check("m49_q_d", 32'(q_d), 32'h5);
    check("m49_vc_p", 32'(vc_p), 32'h2);
    check("m49_vc_d", 32'(vc_d), 32'h1);

    // pulse in flight from edge 50, then asynchronous reset before edge 51
    a = ~a;
    go_to(50);
    check("r50_vc_p", 32'(vc_p), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check("r_async_q_p",   32'(q_p),     32'h0);
    check("r_async_q_d",   32'(q_d),     32'h0);
    check("r_async_ready", 32'(ready_p), 32'h0);
    check("r_async_viol",  32'(viol_d),  32'h0);
    check("r_async_vc",    32'(vc_p),    32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("r_hold_q_p", 32'(q_p), 32'h0);
      check("r_hold_q_d", 32'(q_d), 32'h0);
    end
    rst_n  = 1'b1;
    edge_n = 0;
    go_to(7);
    check("re_ready7", 32'(ready_p), 32'h0);
    check("re_q7",     32'(q_p),     32'h0);
    go_to(8);
    check("re_ready8", 32'(ready_d), 32'h1);
    check("re_viol8",  32'(viol_p),  32'h0);
    go_to(12);
    check("re_q12",    32'(q_d),     32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
